alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational ALU: same op encoding widened to WIDTH bits, result and flags registered.
//  Adds slt/sltu and an optional iterative shift-add multiplier (multi-cycle op).
//  Sits between decode/operand fetch and writeback in the multi-cycle CPU datapath; the pipeline stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH  32  operand/result width; power of two, >= 8. Shift amount uses the low $clog2(WIDTH) bits of x.
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  x          in   WIDTH  operand A (shift amount for shifts)
//  y          in   WIDTH  operand B (value shifted for shifts)
//  alu_ctr    in   4      operation select
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result when out_valid & out_ready
//  z          out  WIDTH  result
//  zero       out  1      z == 0
//  sign       out  1      z[WIDTH-1]
//  overflow   out  1      signed overflow (add/sub); product high half nonzero (mul)
//  carry      out  1      addu carry-out; subu borrow (1 iff x < y unsigned)
//  err        out  1      illegal/unsupported alu_ctr
// BEHAVIOUR
//  Ops: 0 add, 1 sub, 2 addu, 3 subu, 4 sll (y<<sh), 5 srl (y>>sh), 6 sra (y>>>sh), 7 or, 8 nor, 9 xor, 10 and,
//   11 slt (signed x<y -> 1 else 0), 12 sltu (unsigned), 13 mul (unsigned, low WIDTH bits of x*y), 14-15 illegal.
//  Flags not defined for an op are driven 0 (no holding of stale flags). zero/sign computed from registered z.
//  Illegal op: z=0, overflow=carry=0, err=1, zero=1; handled as a 1-cycle op.
//  FSM: IDLE, BUSY (mul iterating), DONE (result held).
//   IDLE: in_ready=1. Accept 1-cycle op -> DONE, outputs loaded at the accepting edge (latency 1). Accept mul -> BUSY.
//   BUSY: in_ready=0; one multiplier bit per cycle, counter loaded with WIDTH at accept; last iteration -> DONE.
//    out_valid rises exactly WIDTH cycles after the accept edge.
//   DONE: out_valid=1; outputs stable while out_ready=0. in_ready=out_ready (back-to-back, throughput 1 op/cycle for 1-cycle ops).
//    out_ready & in_valid -> load new op (DONE or BUSY); out_ready & !in_valid -> IDLE.
//  Arithmetic: add/sub/addu/subu use WIDTH+1-bit sums; subu borrow = ~carry-out of x+~y+1 (no special case for y==0).
//  Reset (any state, including mid-mul): next edge -> IDLE, out_valid=0, z=0, all flags 0, err=0, counter=0; in_ready=1.
//  in_valid while in_ready=0 is ignored (no capture); operands sampled only on the transfer edge.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: op 13 implemented as above (BUSY state and counter present).
//  Not defined: op 13 treated as illegal (err=1, z=0, 1-cycle); BUSY state and multiplier logic not synthesised.
// TESTING (WIDTH=32)
//  add x=7FFFFFFF y=1 -> next cycle out_valid=1, z=80000000, overflow=1, sign=1, zero=0, carry=0.
//  subu x=3 y=5 -> z=FFFFFFFE, carry=1; subu x=5 y=5 -> z=0, zero=1, carry=0; sltu x=1 y=FFFFFFFF -> z=1.
//  sra x=4 y=80000000 -> z=F8000000; sll x=33 y=1 -> z=2 (shamt=1); alu_ctr=15 -> err=1, z=0.
//  Hold out_ready=0 5 cycles after add -> z/flags constant, in_ready=0; then 4 back-to-back ops with out_ready=1 -> 4 results in 4 cycles.
//  MUL_EN: mul x=00010000 y=00010000 -> out_valid 32 cycles after accept, z=0, overflow=1; mul x=6 y=7 -> z=2A, overflow=0.
//  MUL_EN: rst at cycle 10 of a mul -> next cycle out_valid=0, in_ready=1, z=0; without macro mul -> err=1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered WIDTH-bit ALU for the multi-cycle CPU datapath.
// Accepts one operation per in_valid/in_ready transfer and presents the result
// and flags on out_valid/out_ready. Most ops take one cycle. Op 13 (mul) is an
// iterative shift-add multiplier that is built only when ALU_SEQ_MUL_EN is
// defined. Without that macro, op 13 is reported as illegal.

module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [3:0]       alu_ctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             sign,
   output logic             overflow,
   output logic             carry,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ADDU = 4'd2;
   localparam logic [3:0] OP_SUBU = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_AND  = 4'd10;
   localparam logic [3:0] OP_SLT  = 4'd11;
   localparam logic [3:0] OP_SLTU = 4'd12;

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = SHW + 1;
   localparam logic [3:0] OP_MUL = 4'd13;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

   state_t           r_state;
   logic [WIDTH-1:0] r_z;
   logic             r_ovf;
   logic             r_cry;
   logic             r_err;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_z;
   logic             w_ovf;
   logic             w_cry;
   logic             w_err;
   logic             w_accept;

`ifdef ALU_SEQ_MUL_EN
   logic [CW-1:0]        r_count;
   logic [2*WIDTH-1:0]   r_prod;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH:0]       w_hiSum;
   logic [2*WIDTH-1:0]   w_step;
   logic                 w_isMul;
`endif

   // Subtraction is x + ~y + 1, so the borrow is simply the inverted carry-out.
   assign w_sum    = {1'b0, x} + {1'b0, y};
   assign w_diff   = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
   assign w_shamt  = x[SHW-1:0];
   assign w_accept = in_valid & in_ready;

   // Single-cycle result and flag decode. Flags that do not apply to an op stay 0.
   always_comb begin
      w_z   = '0;
      w_ovf = 1'b0;
      w_cry = 1'b0;
      w_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      w_isMul = 1'b0;
`endif
      case (alu_ctr)
         OP_ADD: begin
            w_z   = w_sum[WIDTH-1:0];
            w_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            w_z   = w_diff[WIDTH-1:0];
            w_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (w_diff[WIDTH-1] != x[WIDTH-1]);
         end
         OP_ADDU: begin
            w_z   = w_sum[WIDTH-1:0];
            w_cry = w_sum[WIDTH];
         end
         OP_SUBU: begin
            w_z   = w_diff[WIDTH-1:0];
            w_cry = ~w_diff[WIDTH];
         end
         OP_SLL:  w_z = y << w_shamt;
         OP_SRL:  w_z = y >> w_shamt;
         OP_SRA:  w_z = $unsigned($signed(y) >>> w_shamt);
         OP_OR:   w_z = x | y;
         OP_NOR:  w_z = ~(x | y);
         OP_XOR:  w_z = x ^ y;
         OP_AND:  w_z = x & y;
         OP_SLT:  w_z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_SLTU: w_z = {{(WIDTH-1){1'b0}}, (x < y)};
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  w_isMul = 1'b1;
`endif
         default: w_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // One shift-add step. The low half of r_prod holds the remaining multiplier
   // bits. The high half accumulates the partial product.
   always_comb begin
      w_hiSum = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
      if (r_prod[0]) begin
         w_hiSum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
      end
      w_step = {w_hiSum, r_prod[WIDTH-1:1]};
   end
`endif

   // Control FSM plus registered result and flags. A new op is loaded whenever a
   // transfer happens, whether the block is idle or still presenting a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_z     <= '0;
         r_ovf   <= 1'b0;
         r_cry   <= 1'b0;
         r_err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_count <= '0;
         r_prod  <= '0;
         r_mcand <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
                  if (w_isMul) begin
                     r_state <= S_BUSY;
                     r_count <= CW'(WIDTH);
                     r_prod  <= {{WIDTH{1'b0}}, y};
                     r_mcand <= x;
                  end else
`endif
                  begin
                     r_state <= S_DONE;
                     r_z     <= w_z;
                     r_ovf   <= w_ovf;
                     r_cry   <= w_cry;
                     r_err   <= w_err;
                  end
               end else if ((r_state == S_DONE) && out_ready) begin
                  r_state <= S_IDLE;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            S_BUSY: begin
               r_prod  <= w_step;
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  r_state <= S_DONE;
                  r_z     <= w_step[WIDTH-1:0];
                  r_ovf   <= |w_step[2*WIDTH-1:WIDTH];
                  r_cry   <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // zero is qualified by out_valid so that every flag reads 0 out of reset.
   assign out_valid = (r_state == S_DONE);
   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign z         = r_z;
   assign zero      = out_valid && (r_z == '0);
   assign sign      = r_z[WIDTH-1];
   assign overflow  = r_ovf;
   assign carry     = r_cry;
   assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32.
// The driver pushes the reference result for each transfer into a queue.
// A separate monitor compares every presented result against the front of
// that queue and pops it on the out handshake.
// Mul expectations follow ALU_SEQ_MUL_EN, the same macro the design uses.

module tb_alu_seq;

   localparam int WIDTH = 32;

`ifdef ALU_SEQ_MUL_EN
   localparam int MUL_LAT = 32;
`endif

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] x         = '0;
   logic [WIDTH-1:0] y         = '0;
   logic [3:0]       alu_ctr   = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] z;
   logic             zero;
   logic             sign;
   logic             overflow;
   logic             carry;
   logic             err;

   // bits = {z, zero, sign, overflow, carry, err}
   // lat is the number of edges after the accepting edge before the result shows.
   typedef struct {
      logic [36:0] bits;
      int          lat;
      longint      acceptAt;
   } expT;

   expT    scoreQ[$];
   int     compared    = 0;
   int     mismatched  = 0;
   longint cycleCount  = 0;
   longint frontSeenAt = -1;
   bit     randomReady = 1'b0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .alu_ctr   (alu_ctr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .zero      (zero),
      .sign      (sign),
      .overflow  (overflow),
      .carry     (carry),
      .err       (err)
   );

   // Free-running clock and edge counter used for latency bookkeeping.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Reference model written directly from the op definitions using 64-bit arithmetic.
   function automatic expT model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      expT         e;
      longint      sa;
      longint      sb;
      longint      r;
      logic [63:0] u;
      logic [31:0] res;
      logic        ovf;
      logic        cry;
      logic        bad;
      int          sh;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sh  = int'(a % 32);
      res = '0;
      ovf = 1'b0;
      cry = 1'b0;
      bad = 1'b0;
      e.lat = 0;
      e.acceptAt = 0;
      case (op)
         4'd0: begin
            r = sa + sb;
            res = r[31:0];
            ovf = (r != longint'($signed(res)));
         end
         4'd1: begin
            r = sa - sb;
            res = r[31:0];
            ovf = (r != longint'($signed(res)));
         end
         4'd2: begin
            u = 64'(a) + 64'(b);
            res = u[31:0];
            cry = (u > 64'h0000_0000_FFFF_FFFF);
         end
         4'd3: begin
            res = a - b;
            cry = (a < b);
         end
         4'd4:  res = b << sh;
         4'd5:  res = b >> sh;
         4'd6:  res = $signed(b) >>> sh;
         4'd7:  res = a | b;
         4'd8:  res = ~(a | b);
         4'd9:  res = a ^ b;
         4'd10: res = a & b;
         4'd11: res = (sa < sb) ? 32'd1 : 32'd0;
         4'd12: res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
         4'd13: begin
            u = 64'(a) * 64'(b);
            res = u[31:0];
            ovf = (u[63:32] != 32'd0);
            e.lat = MUL_LAT;
         end
`endif
         default: bad = 1'b1;
      endcase
      e.bits = {res, (res == 32'd0), res[31], ovf, cry, bad};
      return e;
   endfunction

   // Boundary operands show up often so that the carry, overflow and sign corners get hit.
   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Presents one op, waits for the transfer and records its expected response.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      expT e;
      int  waited;
      bit  accepted;
      waited   = 0;
      accepted = 1'b0;
      alu_ctr  = op;
      x        = a;
      y        = b;
      in_valid = 1'b1;
      while (!accepted) begin
         @(negedge clk);
         if (in_ready) begin
            e = model(op, a, b);
            e.acceptAt = cycleCount + 1;
            scoreQ.push_back(e);
            accepted = 1'b1;
         end else if (++waited > 200) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: in_ready stayed 0 for op %0d", op);
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Applies reset for one edge and checks that the block comes back idle and cleared.
   task automatic resetAndCheck(input string name);
      rst      = 1'b1;
      in_valid = 1'b0;
      scoreQ.delete();
      frontSeenAt = -1;
      @(posedge clk);
      #1;
      checkOutput(name, 64'({out_valid, in_ready, z, zero, sign, overflow, carry, err}),
                  64'({1'b0, 1'b1, 32'd0, 5'b00000}));
      rst = 1'b0;
   endtask

   // Monitor: every cycle that a result is presented it must match the queue front.
   // This also confirms that a stalled result holds steady and that in_ready follows out_ready.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (scoreQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedOutput: out_valid with z=%h and nothing outstanding", z);
         end else begin
            if (frontSeenAt < 0) frontSeenAt = cycleCount;
            checkOutput("result", 64'({z, zero, sign, overflow, carry, err}), 64'(scoreQ[0].bits));
            checkOutput("inReadyInDone", 64'(in_ready), 64'(out_ready));
            if (out_ready) begin
               checkOutput("latency", 64'(frontSeenAt - scoreQ[0].acceptAt), 64'(scoreQ[0].lat));
               void'(scoreQ.pop_front());
               frontSeenAt = -1;
            end
         end
      end
   end

   // Randomised consumer back-pressure, active only during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Hard time limit so that a hung handshake still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed corner cases, stall, back-to-back, mul, random, drain.
   initial begin
      longint t0;
      int     drain;
      logic [3:0] op;
      repeat (2) @(posedge clk);
      #1;
      resetAndCheck("resetState");

      applyStimulus(4'd0,  32'h7FFF_FFFF, 32'h0000_0001);
      applyStimulus(4'd3,  32'h0000_0003, 32'h0000_0005);
      applyStimulus(4'd3,  32'h0000_0005, 32'h0000_0005);
      applyStimulus(4'd12, 32'h0000_0001, 32'hFFFF_FFFF);
      applyStimulus(4'd6,  32'h0000_0004, 32'h8000_0000);
      applyStimulus(4'd4,  32'h0000_0021, 32'h0000_0001);
      applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
      applyStimulus(4'd14, 32'h0000_0001, 32'h0000_0001);
      applyStimulus(4'd11, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(4'd1,  32'h8000_0000, 32'h0000_0001);
      applyStimulus(4'd2,  32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(4'd5,  32'h0000_001F, 32'h8000_0000);
      applyStimulus(4'd8,  32'h0F0F_0000, 32'h0000_00F0);

      // Stall: keep the consumer off for five cycles while an add result is held.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(4'd0, 32'h0000_1234, 32'h0000_4321);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Four single-cycle ops back to back must take four edges in total.
      t0 = cycleCount;
      applyStimulus(4'd9,  32'hA5A5_A5A5, 32'hFFFF_0000);
      applyStimulus(4'd10, 32'hA5A5_A5A5, 32'hFFFF_0000);
      applyStimulus(4'd7,  32'h0000_0000, 32'h0000_0000);
      applyStimulus(4'd1,  32'h0000_0005, 32'h0000_0007);
      checkOutput("backToBackCycles", 64'(cycleCount - t0), 64'd4);

      applyStimulus(4'd13, 32'h0001_0000, 32'h0001_0000);
      applyStimulus(4'd13, 32'h0000_0006, 32'h0000_0007);

`ifdef ALU_SEQ_MUL_EN
      // Reset in the middle of a multiply abandons it.
      drain = 0;
      while (scoreQ.size() != 0 && drain < 100) begin
         @(posedge clk);
         drain++;
      end
      #1;
      applyStimulus(4'd13, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (9) @(posedge clk);
      #1;
      resetAndCheck("resetMidMul");
`endif

      // Random phase with random gaps and random consumer back-pressure.
      randomReady = 1'b1;
      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom_range(0, 15));
         applyStimulus(op, randOperand(), randOperand());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      randomReady = 1'b0;
      out_ready   = 1'b1;

      drain = 0;
      while (scoreQ.size() != 0 && drain < 200) begin
         @(posedge clk);
         drain++;
      end
      @(negedge clk);
      if (scoreQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drainTimeout: %0d results still outstanding", scoreQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
